alu_seq: RTL



---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_muldiv.sv | 52 +++++
 rtl/alu_seq.sv | 90 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and op-class decode masks for alu_seq
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13
  } alu_op_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [15:0] ITER_OPS = 16'h3c00;
  localparam logic [15:0] DIV_OPS  = 16'h3000;
endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: shared 1-bit/cycle shift-add multiplier and restoring divider; start(a,b,mode: 0 mul/1 div) -> done pulse after N steps, hi/lo = product or {remainder, quotient}
module alu_muldiv #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);
  localparam int CW = $clog2(N) + 1;
  logic [2*N-1:0] acc, src, nxt;
  logic [N-1:0]   b_r, opb;
  logic [N:0]     mul_sum, rem, rem_sub;
  logic [CW-1:0]  cnt;
  logic           mode_r, md, busy, qb;
  assign src     = start ? {{N{1'b0}}, a} : acc;
  assign opb     = start ? b : b_r;
  assign md      = start ? mode : mode_r;
  assign mul_sum = {1'b0, src[2*N-1:N]} + {1'b0, src[0] ? opb : {N{1'b0}}};
  assign rem     = src[2*N-1:N-1];
  assign rem_sub = rem - {1'b0, opb};
  assign qb      = !rem_sub[N];
  assign nxt     = md ? {qb ? rem_sub[N-1:0] : rem[N-1:0], src[N-2:0], qb} : {mul_sum, src[N-1:1]};
  assign done    = busy && cnt == CW'(N);
  assign hi      = acc[2*N-1:N];
  assign lo      = acc[N-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      b_r    <= '0;
      mode_r <= 1'b0;
      busy   <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= nxt;
      b_r    <= b;
      mode_r <= mode;
      busy   <= 1'b1;
      cnt    <= CW'(1);
    end else if (done) begin
      busy   <= 1'b0;
    end else if (busy) begin
      acc    <= nxt;
      cnt    <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready in and out; ports clk, rst, in_valid/in_ready/op/x/y in, out_valid/out_ready/z/zf/cf/of out
module alu_seq
  import alu_pkg::*;
#(
  parameter  int N  = 32,
  localparam int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] z,
  output logic         zf,
  output logic         cf,
  output logic         of
);
  state_t       state, state_n;
  alu_op_t      op_e;
  logic [N:0]   sum, diff;
  logic [N-1:0] res, md_hi, md_lo, md_res;
  logic [SW-1:0] shamt;
  logic         accept, go_iter, md_done, hi_sel, cf_c, of_c;
  assign op_e      = alu_op_t'(op);
  assign in_ready  = state == IDLE && !rst;
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready;
  // division by zero resolves immediately instead of iterating
  assign go_iter   = ITER_OPS[op] && !(DIV_OPS[op] && y == '0);
  assign sum       = {1'b0, x} + {1'b0, y};
  assign diff      = {1'b0, x} - {1'b0, y};
  assign shamt     = y[SW-1:0];
  assign cf_c      = op_e == OP_ADD ? sum[N] : op_e == OP_SUB ? diff[N] : 1'b0;
  assign of_c      = op_e == OP_ADD ? x[N-1] == y[N-1] && sum[N-1] != x[N-1] :
                     op_e == OP_SUB ? x[N-1] != y[N-1] && diff[N-1] != x[N-1] : 1'b0;
  assign md_res    = hi_sel ? md_hi : md_lo;
  always_comb begin
    res = '0;
    case (op_e)
      OP_ADD:  res = sum[N-1:0];
      OP_SUB:  res = diff[N-1:0];
      OP_AND:  res = x & y;
      OP_OR:   res = x | y;
      OP_XOR:  res = x ^ y;
      OP_SLT:  res = {{(N-1){1'b0}}, $signed(x) < $signed(y)};
      OP_SLTU: res = {{(N-1){1'b0}}, x < y};
      OP_SLL:  res = x << shamt;
      OP_SRL:  res = x >> shamt;
      OP_SRA:  res = $signed(x) >>> shamt;
      OP_DIVU: res = '1;
      OP_REMU: res = x;
      default: res = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? (go_iter ? CALC : DONE) : IDLE) :
              state == CALC ? (md_done ? DONE : CALC) :
              (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {z, zf, cf, of} <= '0;
      hi_sel <= 1'b0;
    end else begin
      if (accept) hi_sel <= op_e == OP_MULHU || op_e == OP_REMU;
      if (accept && !go_iter) {z, zf, cf, of} <= {res, res == '0, cf_c, of_c};
      if (state == CALC && md_done) {z, zf, cf, of} <= {md_res, md_res == '0, 2'b00};
    end
  end
  alu_muldiv #(.N(N)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (accept && go_iter),
    .mode  (DIV_OPS[op]),
    .a     (x),
    .b     (y),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );
endmodule
